exp2x_seq: RTL and testbench

//   Sequential base-2 antilog: y = 2^x. This is the inverse of the log2X block.
//   x is an unsigned fixed-point log value: 6 integer bits, 5 fraction bits.

---
 rtl/exp2x_seq.sv | 126 ++++++++++++
 tb/tb_exp2x_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exp2x_seq.sv
`default_nettype none
// ============================================================================
// Module   : exp2x_seq
// Brief    : Sequential base-2 antilog, y = 2^x. One ROM multiply per
//            fraction bit of x (MSB first), then a shift by the integer part.
//            x is Q(IW).(FW) unsigned, y is Q(OIW).(OFW) unsigned.
// Revision : 1.0 - initial release
// ============================================================================
module exp2x_seq #(
   parameter int IW  = 6,   // integer bits of x
   parameter int FW  = 5,   // fraction bits of x, one CALC cycle each (1..8)
   parameter int OIW = 5,   // integer bits of y
   parameter int OFW = 3,   // fraction bits of y
   parameter int MW  = 16   // fraction bits of the Q1.MW mantissa
) (
   input  logic                 clk,
   input  logic                 rst,     // asynchronous, active low
   input  logic                 start,
   input  logic [IW+FW-1:0]     x,
   output logic                 busy,
   output logic                 done,
   output logic [OIW+OFW-1:0]   y
);

   localparam int KW = 4;   // holds k = 1..8

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CALC  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [MW:0] C_ONE = {1'b1, {MW{1'b0}}};

   // C[k] = round(2^(2^-k) * 2^16); table is tabulated for the Q1.16 mantissa
   function automatic logic [MW:0] f_rom(input logic [KW-1:0] k);
      logic [16:0] c16;
      case (k)
         4'd1:    c16 = 17'h16A0A;
         4'd2:    c16 = 17'h13070;
         4'd3:    c16 = 17'h1172C;
         4'd4:    c16 = 17'h10B56;
         4'd5:    c16 = 17'h1059B;
         4'd6:    c16 = 17'h102CA;
         4'd7:    c16 = 17'h10164;
         4'd8:    c16 = 17'h100B2;
         default: c16 = 17'h10000;
      endcase
      f_rom = (MW+1)'(c16);
   endfunction

   logic [1:0]          r_state;
   logic [IW-1:0]       r_xi;
   logic [FW-1:0]       r_xf;     // shifted left each CALC cycle; MSB is bit k
   logic [MW:0]         r_m;
   logic [KW-1:0]       r_k;
   logic [OIW+OFW-1:0]  r_y;

   logic [MW:0]         w_c;
   logic [2*MW+1:0]     w_prod;
   logic [MW:0]         w_mnext;
   logic                w_sat;
   logic [MW+OIW-1:0]   w_shl;
   logic [OIW+OFW-1:0]  w_ynext;
   logic                w_unused;

   // Mantissa step: m * C[k], truncated back to Q1.MW
   assign w_c     = f_rom(r_k);
   assign w_prod  = {{(MW+1){1'b0}}, r_m} * {{(MW+1){1'b0}}, w_c};
   assign w_mnext = w_prod[2*MW:MW];

   // Final scaling: shift by the integer part, keep OFW fraction bits
   assign w_sat   = (r_xi >= IW'(OIW));
   assign w_shl   = {{(OIW-1){1'b0}}, r_m} << r_xi;
   assign w_ynext = w_shl[MW+OIW-1:MW-OFW];

   // Product top bit is always zero since m stays below 2.0; dropped low bits truncate
   assign w_unused = ^{w_prod[2*MW+1], w_prod[MW-1:0], w_shl[MW-OFW-1:0]};

   // Conversion FSM: accept, iterate over fraction bits, scale, report
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_xi    <= '0;
         r_xf    <= '0;
         r_m     <= '0;
         r_k     <= '0;
         r_y     <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_xi    <= x[IW+FW-1:FW];
                  r_xf    <= x[FW-1:0];
                  r_m     <= C_ONE;
                  r_k     <= KW'(1);
                  r_state <= S_CALC;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CALC: begin
               if (r_xf[FW-1]) begin
                  r_m <= w_mnext;
               end
               r_xf <= r_xf << 1;
               if (r_k == KW'(FW)) begin
                  r_state <= S_SHIFT;
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            S_SHIFT: begin
               r_y     <= w_sat ? '1 : w_ynext;
               r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy = (r_state == S_CALC) || (r_state == S_SHIFT);
   assign done = (r_state == S_DONE);
   assign y    = r_y;

endmodule
`default_nettype wire

// File: tb/tb_exp2x_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_exp2x_seq
// Brief    : Scoreboard bench for exp2x_seq. A reference model computes 2^x
//            from real-valued ROM constants and plain integer arithmetic;
//            a negedge monitor compares every done against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exp2x_seq;

   localparam int IW  = 6;
   localparam int FW  = 5;
   localparam int OIW = 5;
   localparam int OFW = 3;
   localparam int MW  = 16;

   logic          clk   = 1'b0;
   logic          rst   = 1'b0;
   logic          start = 1'b0;
   logic [10:0]   x     = '0;
   logic          busy;
   logic          done;
   logic [7:0]    y;

   exp2x_seq #(.IW(IW), .FW(FW), .OIW(OIW), .OFW(OFW), .MW(MW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x),
      .busy  (busy),
      .done  (done),
      .y     (y)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] ym;     // model result
      bit         has;    // a literal expectation is attached
      logic [7:0] lo;
      logic [7:0] hi;
      longint     due;    // cycle count at which done must be seen
   } exp_t;

   exp_t    q[$];
   longint  c_tab[1:8];
   int      checks   = 0;
   int      failures = 0;
   longint  cyc      = 0;
   longint  free_at  = 0;
   longint  last_acc = 0;
   bit      have_acc = 0;
   bit      dir_has  = 0;
   logic [7:0] dir_lo = '0;
   logic [7:0] dir_hi = '0;
   logic [7:0] last_y = '0;

   // Reference: 2^x from the mathematical definition with MW-bit truncation
   function automatic logic [7:0] exp_model(input logic [10:0] xv);
      longint m  = 64'd1 << MW;
      int     xi = int'(xv >> FW);
      for (int k = 1; k <= FW; k++) begin
         if (xv[FW-k]) m = (m * c_tab[k]) >> MW;
      end
      if (xi >= OIW) return 8'hFF;
      return 8'((m << xi) >> (MW - OFW));
   endfunction

   initial begin
      for (int k = 1; k <= 8; k++) begin
         c_tab[k] = longint'($rtoi((2.0 ** (1.0 / (2.0 ** k))) * 65536.0 + 0.5));
      end
   end

   // Model: decides acceptance from elapsed cycles and queues expectations
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            q.delete();
            cyc      = 0;
            free_at  = 0;
            have_acc = 0;
         end else begin
            if (start && cyc >= free_at) begin
               q.push_back('{exp_model(x), dir_has, dir_lo, dir_hi, cyc + FW + 2});
               last_acc = cyc;
               have_acc = 1;
               free_at  = cyc + FW + 2;
            end
            cyc = cyc + 1;
         end
      end
   end

   // Monitor: reset values, busy profile, held y and every done result
   initial begin
      exp_t e;
      bit   exp_busy;
      forever begin
         @(negedge clk);
         if (!rst) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || y !== 8'h00) begin
               failures++;
               $display("FAIL reset_state busy=%b done=%b y=%h required 0 0 00", busy, done, y);
            end
            last_y = 8'h00;
         end else begin
            exp_busy = have_acc && ((cyc - 1) <= last_acc + FW);
            checks++;
            if (busy !== exp_busy) begin
               failures++;
               $display("FAIL busy cyc=%0d got=%b required=%b", cyc, busy, exp_busy);
            end
            if (done === 1'b1) begin
               if (q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL spurious_done cyc=%0d y=%h", cyc, y);
               end else begin
                  e = q.pop_front();
                  checks++;
                  if (cyc != e.due) begin
                     failures++;
                     $display("FAIL latency cyc=%0d required=%0d", cyc, e.due);
                  end
                  checks++;
                  if (y !== e.ym) begin
                     failures++;
                     $display("FAIL y_model got=%h required=%h", y, e.ym);
                  end
                  if (e.has) begin
                     checks++;
                     if (y < e.lo || y > e.hi) begin
                        failures++;
                        $display("FAIL y_literal got=%h required=%h..%h", y, e.lo, e.hi);
                     end
                  end
               end
               last_y = y;
            end else begin
               checks++;
               if (y !== last_y) begin
                  failures++;
                  $display("FAIL y_held got=%h required=%h", y, last_y);
               end
               if (q.size() > 0 && cyc >= q[0].due) begin
                  e = q.pop_front();
                  checks++;
                  failures++;
                  $display("FAIL missing_done cyc=%0d required_y=%h", cyc, e.ym);
               end
            end
         end
      end
   end

   // Single conversion from idle with an optional literal range
   task automatic conv(input logic [10:0] xv, input bit has,
                       input logic [7:0] lo, input logic [7:0] hi);
      @(negedge clk);
      x       = xv;
      start   = 1'b1;
      dir_has = has;
      dir_lo  = lo;
      dir_hi  = hi;
      @(negedge clk);
      start   = 1'b0;
      dir_has = 1'b0;
      x       = 11'($urandom);
      repeat (FW + 2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      conv(11'b000000_00000, 1, 8'b00001_000, 8'b00001_000);  // 1.0
      conv(11'b000100_00000, 1, 8'b10000_000, 8'b10000_000);  // 16.0
      conv(11'b000001_01000, 1, 8'b00010_011, 8'b00010_011);  // 2.375
      conv(11'b000011_10000, 1, 8'b01011_010, 8'b01011_010);  // 11.25
      conv(11'b000100_11111, 1, 8'b11111_010, 8'b11111_010);  // 31.25
      conv(11'b000101_00000, 1, 8'hFF, 8'hFF);                // saturate
      conv(11'h7FF,          1, 8'hFF, 8'hFF);                // saturate
      conv(11'b000011_11101, 1, 8'd119, 8'd121);              // log2(15) round trip

      // Abort mid-CALC with an asynchronous reset
      @(negedge clk);
      x     = 11'b000011_10101;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);

      // Back-to-back: start held across three conversions
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 3 * (FW + 2); i++) begin
         x = 11'($urandom_range(0, 191));
         @(negedge clk);
      end
      start = 1'b0;
      repeat (FW + 3) @(negedge clk);

      // Random traffic, including start pulses while busy
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 2) == 0);
         x     = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 191));
         @(negedge clk);
      end
      start = 1'b0;
      repeat (FW + 4) @(negedge clk);

      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
